qspi_bus_sniffer: RTL and testbench
===================================

// Module: qspi_bus_sniffer
// PURPOSE
//  Synthesizable, parametrised successor to the sim-only QSPI monitor. Passively
//  oversamples a QSPI bus (SCLK/CS/IO[3:0]/OEN) and decodes single/dual/quad frames
//  for any CPOL/CPHA. Emits byte records (data, direction, SOF/EOF, bit count)
//  into a ready/valid FIFO. Sits beside the soc_top QSPI pins for on-chip trace/debug.
// PARAMETERS
//  CPOL        1'b0  idle SCLK level
//  CPHA        1'b0  0: sample on leading edge, 1: sample on trailing edge
//  SYNC_STAGES 2     input synchronizer depth (>=2)
//  FIFO_DEPTH  16    record FIFO entries; power of 2, >=2
//  CNT_W       16    frame counter width
// PORTS
//  clk_i        in   1      system clock
//  reset_ni     in   1      async active-low reset
//  qspi_sclk_i  in   1      bus SCLK (async)
//  qspi_cs_ni   in   1      bus chip select, active low (async)
//  qspi_do_i    in   4      controller-driven IO
//  qspi_di_i    in   4      device-driven IO
//  qspi_oen_i   in   1      0: controller drives IO, 1: device drives IO
//  lane_mode_i  in   2      0 single, 1 dual, 2 quad, 3 reserved (treated as single)
//  enable_i     in   1      capture enable, sampled at CS fall
//  clear_i      in   1      1-clk pulse: flush FIFO, clear overflow, zero frame count
//  rec_valid_o  out  1      record available
//  rec_ready_i  in   1      consumer accepts record
//  rec_data_o   out  8      byte, MSB-first; partial bytes left-aligned, zero-padded
//  rec_nbits_o  out  4      valid bits in rec_data_o (0..8)
//  rec_dir_o    out  1      1 controller->device, 0 device->controller
//  rec_sof_o    out  1      first record of frame
//  rec_eof_o    out  1      last record of frame
//  level_o      out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//  overflow_o   out  1      sticky: record dropped
//  frame_cnt_o  out  CNT_W  frames captured; wraps
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, FSM IDLE, synchronizers load CS=1, SCLK=CPOL.
//  - All pins pass through SYNC_STAGES flops. Edge detection on the synced SCLK.
//    Sample edge: rising if CPOL==CPHA, else falling. Supported f_sclk <= f_clk/4;
//    faster SCLK is unsupported and is not detected.
//  - FSM IDLE -> ACTIVE on synced CS fall with enable_i=1. On entry: latch lane_mode,
//    bit_cnt=0, sof_pend=1, frame_cnt++. CS fall with enable_i=0 -> SKIP; SKIP -> IDLE on CS rise.
//  - ACTIVE, sample edge: bits = oen ? di : do. Single: MOSI=IO0, MISO=IO1. Dual: IO[1:0].
//    Quad: IO[3:0]. Shift MSB-first; bit_cnt += lanes. Byte direction = ~oen at the
//    byte's first sample. bit_cnt==8 -> push {data, nbits=8, dir, sof=sof_pend, eof=0};
//    clear sof_pend; bit_cnt=0.
//  - ACTIVE -> FLUSH on CS rise. FLUSH pushes exactly one eof=1 record, then goes to IDLE:
//    if bit_cnt>0 it carries the partial bits (nbits=bit_cnt); else data=0, nbits=0.
//    sof = sof_pend, so an empty frame gives one record with sof=eof=1.
//    Sample edges while CS is high are ignored.
//  - FIFO: show-ahead. Push in cycle N -> rec_valid_o=1 in N+1. Pop = valid&ready.
//    Push is accepted if level<FIFO_DEPTH or a pop happens in the same cycle; otherwise
//    the record is dropped and overflow_o=1 (sticky).
//  - clear_i: FIFO empties, overflow_o=0, frame_cnt=0 next cycle. An in-progress frame
//    continues and its remaining records are captured. A push coinciding with clear_i
//    is discarded.
//  - Async reset mid-frame aborts immediately. The next CS fall starts a clean frame.
//  - Latency pin edge -> record valid: SYNC_STAGES+2 clk.
// TESTING
//  1 Mode0 single: 0x9F on IO0, CS rise -> {9F,n8,dir1,sof}, {00,n0,eof}; frame_cnt=1.
//  2 Quad: ctrl 0xA5 (2 edges), then oen=1, dev 0x3C -> {A5,dir1,sof}, {3C,dir0},
//    {00,n0,eof}.
//  3 Partial single: 11 bits 0xB5 then 101 -> {B5,n8,sof}, {A0,n3,eof}.
//  4 FIFO_DEPTH=4, ready=0, 5-byte frame -> level=4, overflow=1, first 4 bytes kept;
//    clear_i -> level=0, overflow=0, frame_cnt=0.
//  5 reset_ni low after 4 bits -> valid=0, level=0, frame_cnt=0 at once;
//    next frame 0x11 -> {11,sof} clean.
//  6 CPOL=1,CPHA=1: 0x5A decoded on rising edges; CS fall with enable_i=0 -> no records,
//    frame_cnt unchanged.

Source files
------------

// File: rtl/qspi_bus_sniffer.sv
// Passive QSPI bus sniffer: oversamples SCLK/CS/IO, decodes single/dual/quad frames
// for any CPOL/CPHA and queues byte records in a show-ahead ready/valid FIFO.
module qspi_bus_sniffer #(
    parameter logic        CPOL        = 1'b0,
    parameter logic        CPHA        = 1'b0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          qspi_sclk_i,
    input  logic                          qspi_cs_ni,
    input  logic [3:0]                    qspi_do_i,
    input  logic [3:0]                    qspi_di_i,
    input  logic                          qspi_oen_i,
    input  logic [1:0]                    lane_mode_i,
    input  logic                          enable_i,
    input  logic                          clear_i,
    output logic                          rec_valid_o,
    input  logic                          rec_ready_i,
    output logic [7:0]                    rec_data_o,
    output logic [3:0]                    rec_nbits_o,
    output logic                          rec_dir_o,
    output logic                          rec_sof_o,
    output logic                          rec_eof_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o,
    output logic [CNT_W-1:0]              frame_cnt_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned PW = 11;
    localparam logic [PW-1:0] SYNC_RST = {CPOL, 1'b1, 9'b0};

    typedef enum logic [1:0] {IDLE, ACTIVE, SKIP, FLUSH} state_t;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] nbits;
        logic       dir;
        logic       sof;
        logic       eof;
    } rec_t;

    // Pin bundle {sclk, cs_n, oen, do[3:0], di[3:0]} through the synchronizer chain
    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] pins_s;
    logic          sclk_s, cs_s, oen_s;
    logic [3:0]    do_s, di_s;
    logic          sclk_d, cs_d;
    logic          sample, cs_fall;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
            sclk_d <= CPOL;
            cs_d   <= 1'b1;
        end else begin
            sync_q[0] <= {qspi_sclk_i, qspi_cs_ni, qspi_oen_i, qspi_do_i, qspi_di_i};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    assign pins_s  = sync_q[SYNC_STAGES-1];
    assign sclk_s  = pins_s[10];
    assign cs_s    = pins_s[9];
    assign oen_s   = pins_s[8];
    assign do_s    = pins_s[7:4];
    assign di_s    = pins_s[3:0];
    assign sample  = (CPOL == CPHA) ? (sclk_s & ~sclk_d) : (~sclk_s & sclk_d);
    assign cs_fall = cs_d & ~cs_s;

    state_t           state, state_n;
    logic [1:0]       mode_q, mode_n;
    logic [7:0]       shreg, shreg_n, shift_next;
    logic [3:0]       bit_cnt, bit_cnt_n, lanes, bit_sum;
    logic             dir_q, dir_n, dir_cur;
    logic             sof_pend, sof_pend_n;
    logic [CNT_W-1:0] frame_cnt, frame_cnt_n;
    logic             push;
    rec_t             push_rec;
    logic [3:0]       io;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state     <= IDLE;
            mode_q    <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            dir_q     <= 1'b0;
            sof_pend  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_n;
            mode_q    <= mode_n;
            shreg     <= shreg_n;
            bit_cnt   <= bit_cnt_n;
            dir_q     <= dir_n;
            sof_pend  <= sof_pend_n;
            frame_cnt <= frame_cnt_n;
        end
    end

    always_comb begin
        io = oen_s ? di_s : do_s;
        case (mode_q)
            2'd1: begin
                lanes      = 4'd2;
                shift_next = {shreg[5:0], io[1:0]};
            end
            2'd2: begin
                lanes      = 4'd4;
                shift_next = {shreg[3:0], io};
            end
            default: begin
                lanes      = 4'd1;
                shift_next = {shreg[6:0], oen_s ? io[1] : io[0]};
            end
        endcase
        bit_sum = bit_cnt + lanes;
        dir_cur = (bit_cnt == 4'd0) ? ~oen_s : dir_q;
    end

    always_comb begin
        state_n     = state;
        mode_n      = mode_q;
        shreg_n     = shreg;
        bit_cnt_n   = bit_cnt;
        dir_n       = dir_q;
        sof_pend_n  = sof_pend;
        frame_cnt_n = frame_cnt;
        push        = 1'b0;
        push_rec    = '0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    if (enable_i) begin
                        state_n     = ACTIVE;
                        mode_n      = lane_mode_i;
                        bit_cnt_n   = '0;
                        shreg_n     = '0;
                        sof_pend_n  = 1'b1;
                        frame_cnt_n = frame_cnt + CNT_W'(1);
                    end else begin
                        state_n = SKIP;
                    end
                end
            end
            ACTIVE: begin
                // CS high takes priority: a sample edge coincident with CS rise is ignored
                if (cs_s) begin
                    state_n = FLUSH;
                end else if (sample) begin
                    shreg_n = shift_next;
                    dir_n   = dir_cur;
                    if (bit_sum == 4'd8) begin
                        push       = 1'b1;
                        push_rec   = '{data: shift_next, nbits: 4'd8, dir: dir_cur,
                                       sof: sof_pend, eof: 1'b0};
                        sof_pend_n = 1'b0;
                        bit_cnt_n  = '0;
                    end else begin
                        bit_cnt_n = bit_sum;
                    end
                end
            end
            FLUSH: begin
                push       = 1'b1;
                push_rec   = '{data: shreg << (4'd8 - bit_cnt), nbits: bit_cnt, dir: dir_q,
                               sof: sof_pend, eof: 1'b1};
                sof_pend_n = 1'b0;
                bit_cnt_n  = '0;
                state_n    = IDLE;
            end
            SKIP: begin
                if (cs_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (clear_i) frame_cnt_n = '0;
    end

    rec_t          mem [FIFO_DEPTH];
    rec_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          valid, pop, push_ok, ovf;

    assign valid   = (level != '0);
    assign pop     = valid & rec_ready_i;
    assign push_ok = push & ~clear_i & ((level != LW'(FIFO_DEPTH)) | pop);

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= push_rec;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (push && !push_ok) ovf <= 1'b1;
        end
    end

    // Storage is not reset, so record fields are gated to read zero while empty
    assign head        = mem[rd_ptr];
    assign rec_valid_o = valid;
    assign rec_data_o  = valid ? head.data  : '0;
    assign rec_nbits_o = valid ? head.nbits : '0;
    assign rec_dir_o   = valid & head.dir;
    assign rec_sof_o   = valid & head.sof;
    assign rec_eof_o   = valid & head.eof;
    assign level_o     = level;
    assign overflow_o  = ovf;
    assign frame_cnt_o = frame_cnt;

endmodule

// File: tb/tb_qspi_bus_sniffer.sv
// Directed bench for qspi_bus_sniffer: three instances (mode 0 depth 16, mode 0 depth 4,
// mode 3) share one bit-banged bus; per-instance enable selects which one captures.
module tb_qspi_bus_sniffer;

    logic        clk = 1'b0;
    logic        rst0, rst_oth;
    logic        sclk, cs_n, oen;
    logic [3:0]  bus_do, bus_di;
    logic [1:0]  lane;
    logic        en [3];
    logic        clr [3];
    logic        rdy [3];
    logic        vld [3];
    logic [7:0]  data [3];
    logic [3:0]  nbits [3];
    logic        dir [3], sof [3], eof [3], ovf [3];
    logic [15:0] fcnt [3];
    logic [4:0]  lvl0, lvl11;
    logic [2:0]  lvl4;
    logic [14:0] rec [3];

    int compared   = 0;
    int mismatched = 0;
    bit cpol = 1'b0;
    bit cpha = 1'b0;

    always #5 clk = ~clk;

    qspi_bus_sniffer #(.CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2), .FIFO_DEPTH(16), .CNT_W(16)) dut0 (
        .clk_i(clk), .reset_ni(rst0), .qspi_sclk_i(sclk), .qspi_cs_ni(cs_n),
        .qspi_do_i(bus_do), .qspi_di_i(bus_di), .qspi_oen_i(oen), .lane_mode_i(lane),
        .enable_i(en[0]), .clear_i(clr[0]), .rec_valid_o(vld[0]), .rec_ready_i(rdy[0]),
        .rec_data_o(data[0]), .rec_nbits_o(nbits[0]), .rec_dir_o(dir[0]), .rec_sof_o(sof[0]),
        .rec_eof_o(eof[0]), .level_o(lvl0), .overflow_o(ovf[0]), .frame_cnt_o(fcnt[0]));

    qspi_bus_sniffer #(.CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2), .FIFO_DEPTH(4), .CNT_W(16)) dut4 (
        .clk_i(clk), .reset_ni(rst_oth), .qspi_sclk_i(sclk), .qspi_cs_ni(cs_n),
        .qspi_do_i(bus_do), .qspi_di_i(bus_di), .qspi_oen_i(oen), .lane_mode_i(lane),
        .enable_i(en[1]), .clear_i(clr[1]), .rec_valid_o(vld[1]), .rec_ready_i(rdy[1]),
        .rec_data_o(data[1]), .rec_nbits_o(nbits[1]), .rec_dir_o(dir[1]), .rec_sof_o(sof[1]),
        .rec_eof_o(eof[1]), .level_o(lvl4), .overflow_o(ovf[1]), .frame_cnt_o(fcnt[1]));

    qspi_bus_sniffer #(.CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2), .FIFO_DEPTH(16), .CNT_W(16)) dut11 (
        .clk_i(clk), .reset_ni(rst_oth), .qspi_sclk_i(sclk), .qspi_cs_ni(cs_n),
        .qspi_do_i(bus_do), .qspi_di_i(bus_di), .qspi_oen_i(oen), .lane_mode_i(lane),
        .enable_i(en[2]), .clear_i(clr[2]), .rec_valid_o(vld[2]), .rec_ready_i(rdy[2]),
        .rec_data_o(data[2]), .rec_nbits_o(nbits[2]), .rec_dir_o(dir[2]), .rec_sof_o(sof[2]),
        .rec_eof_o(eof[2]), .level_o(lvl11), .overflow_o(ovf[2]), .frame_cnt_o(fcnt[2]));

    for (genvar g = 0; g < 3; g++) begin : g_rec
        assign rec[g] = {data[g], nbits[g], dir[g], sof[g], eof[g]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One SCLK period (80 ns); the non-sampled IO bank carries the complement as a decoy
    task automatic beat(input logic [3:0] chunk, input int lanes, input bit dev);
        logic [3:0] v;
        v = (lanes == 1) ? (dev ? {2'b0, chunk[0], 1'b0} : {3'b0, chunk[0]}) : chunk;
        if (!cpha) begin
            oen = dev; bus_do = dev ? ~v : v; bus_di = dev ? v : ~v;
            #40 sclk = ~cpol;
            #40 sclk = cpol;
        end else begin
            sclk = ~cpol;
            #20 oen = dev; bus_do = dev ? ~v : v; bus_di = dev ? v : ~v;
            #20 sclk = cpol;
            #40;
        end
    endtask

    task automatic send(input logic [7:0] val, input int nbits, input int lanes, input bit dev);
        logic [7:0] v;
        v = val;
        for (int i = 0; i < nbits; i += lanes) begin
            beat(4'(v >> (8 - lanes)), lanes, dev);
            v = v << lanes;
        end
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        #80;
    endtask

    task automatic cs_high();
        #40 cs_n = 1'b1;
        #200;
        @(negedge clk);
    endtask

    task automatic expect_rec(input int d, input string tag, input logic [7:0] edata,
                              input logic [3:0] enb, input bit edir, input bit esof,
                              input bit eeof, input bit dir_care);
        logic [14:0] mask;
        mask = dir_care ? 15'h7fff : 15'h7ffb;
        for (int i = 0; i < 100; i++) begin
            if (vld[d]) break;
            @(negedge clk);
        end
        chk({tag, "_valid"}, 32'(vld[d]), 32'd1);
        chk(tag, 32'(rec[d] & mask), 32'({edata, enb, edir, esof, eeof} & mask));
        rdy[d] = 1'b1;
        @(negedge clk);
        rdy[d] = 1'b0;
    endtask

    initial begin
        rst0 = 1'b0; rst_oth = 1'b0;
        sclk = 1'b0; cs_n = 1'b1; oen = 1'b0; bus_do = '0; bus_di = '0; lane = 2'd0;
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b0; clr[i] = 1'b0; rdy[i] = 1'b0;
        end
        #23;
        chk("rst_valid", 32'(vld[0]), 32'd0);
        chk("rst_rec", 32'(rec[0]), 32'd0);
        chk("rst_level", 32'(lvl0), 32'd0);
        chk("rst_ovf", 32'(ovf[0]), 32'd0);
        chk("rst_fcnt", 32'(fcnt[0]), 32'd0);
        @(negedge clk);
        rst0 = 1'b1; rst_oth = 1'b1;
        repeat (5) @(negedge clk);

        // mode 0 single byte
        en[0] = 1'b1; lane = 2'd0;
        cs_low(); send(8'h9F, 8, 1, 1'b0); cs_high();
        expect_rec(0, "t1_byte", 8'h9F, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_rec(0, "t1_eof", 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_fcnt", 32'(fcnt[0]), 32'd1);
        chk("t1_level", 32'(lvl0), 32'd0);

        // quad: controller byte then device byte
        lane = 2'd2;
        cs_low(); send(8'hA5, 8, 4, 1'b0); send(8'h3C, 8, 4, 1'b1); cs_high();
        expect_rec(0, "t2_ctrl", 8'hA5, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_rec(0, "t2_dev", 8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_rec(0, "t2_eof", 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2_fcnt", 32'(fcnt[0]), 32'd2);

        // dual device byte
        lane = 2'd1;
        cs_low(); send(8'hC6, 8, 2, 1'b1); cs_high();
        expect_rec(0, "t2b_dual", 8'hC6, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_rec(0, "t2b_eof", 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // 11-bit single frame: partial tail left-aligned
        lane = 2'd0;
        cs_low(); send(8'hB5, 8, 1, 1'b0); send(8'hA0, 3, 1, 1'b0); cs_high();
        expect_rec(0, "t3_byte", 8'hB5, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_rec(0, "t3_part", 8'hA0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("t3_fcnt", 32'(fcnt[0]), 32'd4);

        // depth-4 FIFO overflow, then clear
        en[0] = 1'b0; en[1] = 1'b1;
        cs_low();
        for (int b = 1; b <= 5; b++) send(8'(b), 8, 1, 1'b0);
        cs_high();
        chk("t4_level", 32'(lvl4), 32'd4);
        chk("t4_ovf", 32'(ovf[1]), 32'd1);
        chk("t4_fcnt", 32'(fcnt[1]), 32'd1);
        chk("t4_other_fcnt", 32'(fcnt[0]), 32'd4);
        expect_rec(1, "t4_b0", 8'h01, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_rec(1, "t4_b1", 8'h02, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t4_level_pop", 32'(lvl4), 32'd2);
        chk("t4_ovf_sticky", 32'(ovf[1]), 32'd1);
        clr[1] = 1'b1;
        @(negedge clk);
        clr[1] = 1'b0;
        chk("t4_clr_level", 32'(lvl4), 32'd0);
        chk("t4_clr_ovf", 32'(ovf[1]), 32'd0);
        chk("t4_clr_fcnt", 32'(fcnt[1]), 32'd0);
        chk("t4_clr_valid", 32'(vld[1]), 32'd0);

        // async reset mid-frame
        en[1] = 1'b0; en[0] = 1'b1;
        cs_low(); send(8'hC3, 8, 1, 1'b0); send(8'hF0, 4, 1, 1'b0);
        #200 @(negedge clk);
        chk("t5_pre_level", 32'(lvl0), 32'd1);
        chk("t5_pre_fcnt", 32'(fcnt[0]), 32'd5);
        #3 rst0 = 1'b0;
        #1;
        chk("t5_valid", 32'(vld[0]), 32'd0);
        chk("t5_level", 32'(lvl0), 32'd0);
        chk("t5_fcnt", 32'(fcnt[0]), 32'd0);
        cs_n = 1'b1; sclk = 1'b0;
        #100 @(negedge clk);
        rst0 = 1'b1;
        repeat (5) @(negedge clk);
        cs_low(); send(8'h11, 8, 1, 1'b0); cs_high();
        expect_rec(0, "t5_byte", 8'h11, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_rec(0, "t5_eof", 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_fcnt_new", 32'(fcnt[0]), 32'd1);

        // CPOL=1, CPHA=1 instance
        en[0] = 1'b0; cpol = 1'b1; cpha = 1'b1; sclk = 1'b1;
        #200 @(negedge clk);
        en[2] = 1'b1;
        cs_low(); send(8'h5A, 8, 1, 1'b0); cs_high();
        expect_rec(2, "t6_byte", 8'h5A, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_rec(2, "t6_eof", 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6_fcnt", 32'(fcnt[2]), 32'd1);
        en[2] = 1'b0;
        cs_low(); send(8'h77, 8, 1, 1'b0); cs_high();
        repeat (10) @(negedge clk);
        chk("t6_skip_valid", 32'(vld[2]), 32'd0);
        chk("t6_skip_level", 32'(lvl11), 32'd0);
        chk("t6_skip_fcnt", 32'(fcnt[2]), 32'd1);
        chk("t6_mode0_fcnt", 32'(fcnt[0]), 32'd1);
        chk("t6_mode0_level", 32'(lvl0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
